// File: rtl/trace_port_tx.sv
// Trace port transmitter: serialises 128-bit TPIU frames (or the 32-bit full-sync
// word when no frame is pending) LSB first onto a 1/2/4-lane DDR trace bus.
// traceDouta carries the first W bits of each cycle's chunk, traceDoutb the next W.

module trace_port_tx #(
   parameter int unsigned SYNC_INTERVAL = 16,
   parameter int unsigned MAX_BUS_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               Width,
   input  logic [127:0]             Frame,
   input  logic                     FrameValid,
   output logic                     FrameNext,
   output logic [MAX_BUS_WIDTH-1:0] traceDouta,
   output logic [MAX_BUS_WIDTH-1:0] traceDoutb,
   output logic                     InFrame,
   output logic [31:0]              FramesSent,
   output logic [15:0]              SyncsSent
);

   localparam logic [127:0] SyncWord = {96'd0, 32'h7FFF_FFFF};

   typedef enum logic {StSync, StFrame} state_e;

   state_e       r_state;
   logic         r_act;     // low only in the cycle right after reset: nothing on the bus yet
   logic [5:0]   r_cyc;     // index of the chunk currently on the outputs
   logic [1:0]   r_wid;     // width code latched at the start of the current word
   logic [127:0] r_sh;      // remaining (not yet emitted) bits of the current word
   logic [7:0]   r_fss;     // frames sent since the last completed sync word

   logic [5:0]   w_last;
   logic         w_bound;
   logic [7:0]   w_fss_done;
   logic         w_go_frame;
   logic         w_start;
   logic         w_take;
   logic [127:0] w_src;
   logic [1:0]   w_wid;
   logic [MAX_BUS_WIDTH-1:0] w_a;
   logic [MAX_BUS_WIDTH-1:0] w_b;
   logic [127:0] w_sh_nxt;

   // Word length and the boundary / next-word decision for the current cycle
   always_comb begin
      w_last = 6'd3;
      unique case (r_wid)
         2'b00:   w_last = (r_state == StFrame) ? 6'd63 : 6'd15;
         2'b01:   w_last = (r_state == StFrame) ? 6'd31 : 6'd7;
         default: w_last = (r_state == StFrame) ? 6'd15 : 6'd3;
      endcase
      w_bound = r_act && (r_cyc == w_last);
      // Count as it will stand once the current word completes
      w_fss_done = (r_state == StFrame) ? (r_fss + 8'd1) : 8'd0;
      w_go_frame = FrameValid &&
                   ((r_state == StSync) || ({24'd0, w_fss_done} < 32'(SYNC_INTERVAL)));
      w_take     = w_bound && w_go_frame;
      w_start    = !r_act || w_bound;
      // FrameNext must answer FrameValid in the same cycle, so it is decoded from state
      FrameNext  = w_take && !rst;
      w_src      = w_take ? Frame : (w_start ? SyncWord : r_sh);
      w_wid      = w_start ? Width : r_wid;
   end

   // Pick the next 2W bits from the word source and shift them out of the register
   always_comb begin
      w_a      = '0;
      w_b      = '0;
      w_sh_nxt = w_src;
      unique case (w_wid)
         2'b00: begin
            w_a[0]   = w_src[0];
            w_b[0]   = w_src[1];
            w_sh_nxt = w_src >> 2;
         end
         2'b01: begin
            w_a[1:0] = w_src[1:0];
            w_b[1:0] = w_src[3:2];
            w_sh_nxt = w_src >> 4;
         end
         default: begin
            w_a[3:0] = w_src[3:0];
            w_b[3:0] = w_src[7:4];
            w_sh_nxt = w_src >> 8;
         end
      endcase
   end

   // Word sequencer: registered bus outputs, state and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StSync;
         r_act      <= 1'b0;
         r_cyc      <= 6'd0;
         r_wid      <= 2'b10;
         r_sh       <= SyncWord;
         r_fss      <= 8'd0;
         traceDouta <= '0;
         traceDoutb <= '0;
         InFrame    <= 1'b0;
         FramesSent <= 32'd0;
         SyncsSent  <= 16'd0;
      end else begin
         r_act      <= 1'b1;
         r_wid      <= w_wid;
         r_sh       <= w_sh_nxt;
         traceDouta <= w_a;
         traceDoutb <= w_b;
         if (w_start) begin
            r_cyc   <= 6'd0;
            r_state <= w_take ? StFrame : StSync;
            InFrame <= w_take;
         end else begin
            r_cyc   <= r_cyc + 6'd1;
         end
         if (w_bound) begin
            if (r_state == StFrame) begin
               FramesSent <= FramesSent + 32'd1;
               r_fss      <= r_fss + 8'd1;
            end else begin
               SyncsSent  <= SyncsSent + 16'd1;
               r_fss      <= 8'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_trace_port_tx.sv
// Scoreboard bench for trace_port_tx: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against two DUTs (SYNC_INTERVAL 16 and 2).

module tb_trace_port_tx;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   Width = 2'b10;
   logic [127:0] Frame = '0;
   logic         FrameValid = 1'b0;

   logic         fn0, fn1, inf0, inf1;
   logic [3:0]   a0, b0, a1, b1;
   logic [31:0]  fs0, fs1;
   logic [15:0]  ss0, ss1;

   trace_port_tx #(.SYNC_INTERVAL(16), .MAX_BUS_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .Width(Width), .Frame(Frame), .FrameValid(FrameValid),
      .FrameNext(fn0), .traceDouta(a0), .traceDoutb(b0), .InFrame(inf0),
      .FramesSent(fs0), .SyncsSent(ss0)
   );

   trace_port_tx #(.SYNC_INTERVAL(2), .MAX_BUS_WIDTH(4)) dut2 (
      .clk(clk), .rst(rst), .Width(Width), .Frame(Frame), .FrameValid(FrameValid),
      .FrameNext(fn1), .traceDouta(a1), .traceDoutb(b1), .InFrame(inf1),
      .FramesSent(fs1), .SyncsSent(ss1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = {a,b,InFrame,FrameNext}, 1 = FramesSent, 2 = SyncsSent, 3 = {InFrame,FrameNext}
   typedef struct {
      int          cyc;
      int          which;
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t        m_e;
   logic [31:0] m_act;

   // Monitor: compare every expectation scheduled for this cycle
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m_e = q.pop_front();
         case (m_e.kind)
            0:       m_act = (m_e.which == 0) ? {22'd0, a0, b0, inf0, fn0}
                                              : {22'd0, a1, b1, inf1, fn1};
            1:       m_act = (m_e.which == 0) ? fs0 : fs1;
            2:       m_act = (m_e.which == 0) ? {16'd0, ss0} : {16'd0, ss1};
            default: m_act = (m_e.which == 0) ? {30'd0, inf0, fn0} : {30'd0, inf1, fn1};
         endcase
         n_tests++;
         if (m_e.cyc != cyc || m_act != m_e.exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d (due %0d): got %h want %h",
                     m_e.name, m_e.which, cyc, m_e.cyc, m_act, m_e.exp);
         end
      end
   end

   function automatic logic [31:0] bus(input logic [3:0] a, input logic [3:0] b,
                                      input logic inf, input logic fn);
      return {22'd0, a, b, inf, fn};
   endfunction

   task automatic push(input int c, input int which, input int kind,
                       input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = c; e.which = which; e.kind = kind; e.exp = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   // Two reset cycles; the cycle where rst drops shows reset values, base is the next one
   task automatic do_reset(output int base);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      push(cyc, 0, 0, 32'd0, "rst_bus");
      push(cyc, 0, 1, 32'd0, "rst_frames");
      push(cyc, 0, 2, 32'd0, "rst_syncs");
      push(cyc, 1, 0, 32'd0, "rst_bus2");
      base = cyc + 1;
   endtask

   logic [127:0] fr_seq;
   int           base;

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      for (int n = 0; n < 16; n++) fr_seq[8*n +: 8] = 8'(n);

      // 1: idle sync words in 4-bit mode
      Width = 2'b10; FrameValid = 1'b0; Frame = fr_seq;
      do_reset(base);
      for (int k = 0; k < 12; k++)
         push(base + k, 0, 0, bus(4'hF, (k % 4 == 3) ? 4'h7 : 4'hF, 1'b0, 1'b0), "t1_sync");
      push(base + 12, 0, 2, 32'd3, "t1_syncs");
      push(base + 12, 0, 1, 32'd0, "t1_frames");
      wait_until(base + 13);
      n_tests++;
      if (ss0 !== 16'd3) begin
         n_fail++;
         $display("FAIL t1_syncs_direct: got %0d want 3", ss0);
      end

      // 2: back-to-back frames in 4-bit mode
      Width = 2'b10; FrameValid = 1'b1; Frame = fr_seq;
      do_reset(base);
      for (int k = 0; k < 4; k++)
         push(base + k, 0, 0, bus(4'hF, (k == 3) ? 4'h7 : 4'hF, 1'b0, k == 3), "t2_sync");
      push(base + 4, 0, 2, 32'd1, "t2_syncs");
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 16; k++)
            push(base + 4 + 16*f + k, 0, 0, bus(4'(k), 4'h0, 1'b1, k == 15), "t2_frame");
         push(base + 20 + 16*f, 0, 1, 32'(f + 1), "t2_frames");
      end
      wait_until(base + 37);

      // 3: forced sync after two frames (dut2), 2-bit mode
      Width = 2'b01; FrameValid = 1'b1; Frame = fr_seq;
      do_reset(base);
      push(base, 1, 0, bus(4'h3, 4'h3, 1'b0, 1'b0), "t3_sync0");
      for (int c = 0; c < 160; c++) begin
         int pos;
         pos = c % 72;
         push(base + c, 1, 3, {30'd0, pos >= 8, (pos == 7) || (pos == 39)}, "t3_pattern");
         if (c == 80) begin
            push(base + c, 1, 2, 32'd2, "t3_syncs");
            push(base + c, 1, 1, 32'd2, "t3_frames");
         end
         if (c == 152) begin
            push(base + c, 1, 2, 32'd3, "t3_syncs");
            push(base + c, 1, 1, 32'd4, "t3_frames");
         end
      end
      wait_until(base + 161);

      // 4: single frame, 1-bit mode, byte0 = A5
      Width = 2'b00; FrameValid = 1'b1; Frame = 128'hA5;
      do_reset(base);
      for (int k = 0; k < 16; k++)
         push(base + k, 0, 0, bus(4'h1, (k == 15) ? 4'h0 : 4'h1, 1'b0, k == 15), "t4_sync");
      push(base + 16, 0, 0, bus(4'h1, 4'h0, 1'b1, 1'b0), "t4_bit01");
      push(base + 17, 0, 0, bus(4'h1, 4'h0, 1'b1, 1'b0), "t4_bit23");
      push(base + 18, 0, 0, bus(4'h0, 4'h1, 1'b1, 1'b0), "t4_bit45");
      push(base + 19, 0, 0, bus(4'h0, 4'h1, 1'b1, 1'b0), "t4_bit67");
      for (int k = 4; k < 64; k++)
         push(base + 16 + k, 0, 0, bus(4'h0, 4'h0, 1'b1, 1'b0), "t4_rest");
      push(base + 80, 0, 0, bus(4'h1, 4'h1, 1'b0, 1'b0), "t4_resync");
      push(base + 80, 0, 1, 32'd1, "t4_frames");
      wait_until(base + 16);
      FrameValid = 1'b0;
      wait_until(base + 81);

      // 5: width change mid-frame takes effect only at the next word
      Width = 2'b10; FrameValid = 1'b1; Frame = fr_seq;
      do_reset(base);
      for (int k = 0; k < 4; k++)
         push(base + k, 0, 0, bus(4'hF, (k == 3) ? 4'h7 : 4'hF, 1'b0, k == 3), "t5_sync");
      for (int k = 0; k < 16; k++)
         push(base + 4 + k, 0, 0, bus(4'(k), 4'h0, 1'b1, 1'b0), "t5_frame");
      for (int k = 0; k < 16; k++)
         push(base + 20 + k, 0, 0, bus(4'h1, (k == 15) ? 4'h0 : 4'h1, 1'b0, 1'b0), "t5_sync1b");
      push(base + 36, 0, 0, bus(4'h1, 4'h1, 1'b0, 1'b0), "t5_nextsync");
      push(base + 36, 0, 2, 32'd2, "t5_syncs");
      wait_until(base + 10);
      Width = 2'b00;
      FrameValid = 1'b0;
      wait_until(base + 37);

      // 6: reset in the middle of a frame
      Width = 2'b10; FrameValid = 1'b1; Frame = fr_seq;
      do_reset(base);
      for (int k = 0; k < 4; k++)
         push(base + k, 0, 0, bus(4'hF, (k == 3) ? 4'h7 : 4'hF, 1'b0, k == 3), "t6_sync");
      for (int k = 0; k < 6; k++)
         push(base + 4 + k, 0, 0, bus(4'(k), 4'h0, 1'b1, 1'b0), "t6_frame");
      push(base + 10, 0, 0, 32'd0, "t6_rst_bus");
      push(base + 10, 0, 1, 32'd0, "t6_rst_frames");
      push(base + 10, 0, 2, 32'd0, "t6_rst_syncs");
      for (int k = 0; k < 4; k++)
         push(base + 11 + k, 0, 0, bus(4'hF, (k == 3) ? 4'h7 : 4'hF, 1'b0, k == 3), "t6_resync");
      push(base + 15, 0, 0, bus(4'h0, 4'h0, 1'b1, 1'b0), "t6_frame0");
      push(base + 15, 0, 1, 32'd0, "t6_frames");
      push(base + 16, 0, 0, bus(4'h1, 4'h0, 1'b1, 1'b0), "t6_frame1");
      wait_until(base + 9);
      rst = 1'b1;
      wait_until(base + 10);
      rst = 1'b0;
      wait_until(base + 17);
      n_tests++;
      if (fs0 !== 32'd0) begin
         n_fail++;
         $display("FAIL t6_frames_direct: got %0d want 0", fs0);
      end

      step();
      step();
      while (q.size() > 0) begin
         m_e = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s never checked: due cyc %0d, now %0d", m_e.name, m_e.cyc, cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_port_tx.md
Name: trace_port_tx

Overview:
- Transmit side of the parallel trace port: serialises 128-bit TPIU frames onto a 1/2/4-bit DDR trace bus.
- Output format is the one the trace receiver expects, so a board can loop its own output back into its input for self-test and production check.
- Sits between a frame source (frame buffer or pattern generator) and the ODDRX1F output cells.
- When no frame is pending, the line carries the TPIU full-sync word.

Parameters:
SYNC_INTERVAL, 16, max consecutive frames sent before a forced full-sync word (1..255)
MAX_BUS_WIDTH, 4, physical lane count of trace outputs (fixed 4; narrower widths leave upper lanes at 0)

Ports:
clk  input  1  system clock; one trace clock period per clk cycle
rst  input  1  synchronous reset, active-high
Width  input  2  bus width: 2'b00=1 bit, 2'b01=2 bits, 2'b10/2'b11=4 bits; sampled only at word start
Frame  input  128  next frame to send, byte 0 in bits [7:0]
FrameValid  input  1  Frame holds a valid frame
FrameNext  output  1  one-cycle pulse: Frame accepted this cycle; source must present next frame or drop FrameValid by next cycle
traceDouta  output  4  data for first (rising) edge, to ODDR D0
traceDoutb  output  4  data for second (falling) edge, to ODDR D1
InFrame  output  1  high while frame bits (not sync) are on the bus
FramesSent  output  32  count of completed frames, wraps
SyncsSent  output  16  count of completed sync words, wraps

Behaviour:
- Reset values:
  - traceDouta=0, traceDoutb=0, FrameNext=0, InFrame=0, FramesSent=0, SyncsSent=0.
  - State=SYNC at bit 0; frames-since-sync counter=0.
- Word transmission:
  - Each word is shifted out LSB first. With W = active width, each cycle emits 2W bits.
  - traceDouta[W-1:0] = bits [2Wk+W-1 : 2Wk]; traceDoutb[W-1:0] = next W bits.
  - Lanes >= W are driven 0.
  - Cycles per frame: 16 (W=4), 32 (W=2), 64 (W=1).
  - Cycles per sync word: 4, 8, 16 respectively.
- Sync word: 32'h7FFF_FFFF, i.e. bytes FF FF FF 7F on the bus.
- States:
  - SYNC: shift sync word.
  - FRAME: shift loaded frame; InFrame=1.
- Decision at the last cycle of any word (the "boundary cycle"):
  - Go to FRAME if FrameValid=1 AND (state==SYNC OR frames-since-sync < SYNC_INTERVAL).
    - FrameNext=1 in this cycle; Frame is captured into the shift register.
    - First frame bits appear on outputs the following cycle; no gap between words.
  - Otherwise go to SYNC; FrameNext stays 0.
- Counters:
  - Frames-since-sync: increments on frame completion, clears on sync completion.
  - FramesSent / SyncsSent: increment in the boundary cycle of a completed frame / sync word.
- Outputs are registered and change only on clk edges. End-to-end latency is 1 cycle from boundary cycle to first bits of the new word.
- Width is latched at each word start. Changing Width mid-word has no effect until the next word.
- FrameValid dropping mid-word: no effect; only the boundary-cycle value matters.
- rst asserted mid-word: the partial word is abandoned, all state returns to reset values, and the next word is a sync starting at bit 0.
- FrameNext is never asserted outside a boundary cycle, nor during rst.

Test Plan:
1. Reset, FrameValid=0, Width=2'b10 for 12 cycles -> each 4-cycle group gives a/b pairs F/F,F/F,F/F,F/7. SyncsSent=3, InFrame=0, FrameNext never high.
2. Width=2'b10, Frame=128'h0F0E..0100 (byte n = n), FrameValid held 1 from reset -> FrameNext pulses at cycle 3. Next 16 cycles give (a,b) = (0,0),(1,0),(2,0)...(F,0), then back-to-back frames. FramesSent increments every 16 cycles.
3. SYNC_INTERVAL=2, FrameValid always 1, Width=2'b01 -> pattern is sync(8 cycles), frame(32), frame(32), sync(8), repeating. SyncsSent/FramesSent ratio is 1:2.
4. Width=2'b00, single frame byte0=8'hA5 -> first 4 cycles a/b are 1/0, 1/0, 0/1, 0/1 (bits LSB first), with traceDouta[3:1]=0.
5. Width changed 2'b10->2'b00 mid-frame -> current frame finishes in 4-bit mode (16 cycles total); the following sync takes 16 cycles.
6. rst pulsed at cycle 5 of a frame -> the next cycle shows all reset values. After release, a full sync is sent before FrameNext can pulse, and FramesSent=0.
